// File: rtl/pkt_transmitter.sv
// pkt_transmitter: arbitrates between register-bank read replies and
// peripheral events, assembles 72-bit SpiNNaker multicast packets with odd
// parity, and hands them to the transceiver through a single registered
// valid/ready output stage.
module pkt_transmitter #(
    parameter int          PACKET_BITS    = 72,
    parameter logic [23:0] REPLY_KEY_BASE = 24'hFFFE00
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [7:0]             rpl_addr_in,
    input  logic [31:0]            rpl_data_in,
    input  logic                   rpl_vld_in,
    output logic                   rpl_rdy_out,

    input  logic [31:0]            evt_key_in,
    input  logic [31:0]            evt_data_in,
    input  logic                   evt_pld_in,
    input  logic                   evt_vld_in,
    output logic                   evt_rdy_out,

    output logic [PACKET_BITS-1:0] pkt_data_out,
    output logic                   pkt_vld_out,
    input  logic                   pkt_rdy_in,

    output logic [1:0]             ptx_cnt_out
);

    // Packet field positions. Bits [3:2], [5] and [7:6] stay zero:
    // multicast type and no emergency-routing marking beyond the type bit.
    localparam int PARITY_BIT = 0;
    localparam int PLD_BIT    = 1;
    localparam int TYPE_BIT   = 4;
    localparam int KEY_LSB    = 8;
    localparam int PAY_LSB    = 40;

    // Which source won the most recent grant; the other one wins the next tie.
    typedef enum logic {
        GRANT_EVT = 1'b0,
        GRANT_RPL = 1'b1
    } grant_t;

    grant_t                  last_grant;
    logic                    stage_free;
    logic                    grant_rpl;
    logic                    grant_evt;
    logic                    grant_any;
    logic [PACKET_BITS-1:0]  asm_pkt_p0;

    // Forces bit 0 so that the XOR over the whole packet is 1.
    function automatic logic [PACKET_BITS-1:0] set_odd_parity(
        input logic [PACKET_BITS-1:0] body
    );
        logic [PACKET_BITS-1:0] pkt;
        pkt             = body;
        pkt[PARITY_BIT] = ~(^body[PACKET_BITS-1:1]);
        return pkt;
    endfunction

    // Lays out header, key and payload; a packet without payload carries zeros.
    function automatic logic [PACKET_BITS-1:0] build_packet(
        input logic        is_reply,
        input logic        has_pld,
        input logic [31:0] key,
        input logic [31:0] payload
    );
        logic [PACKET_BITS-1:0] body;
        body                      = '0;
        body[PLD_BIT]             = has_pld;
        body[TYPE_BIT]            = is_reply;
        body[KEY_LSB +: 32]       = key;
        body[PAY_LSB +: 32]       = has_pld ? payload : 32'h0;
        return set_odd_parity(body);
    endfunction

    // Round-robin grant, only when the output register can take a packet.
    always_comb begin
        stage_free = !pkt_vld_out || pkt_rdy_in;
        grant_rpl  = !reset && stage_free && rpl_vld_in &&
                     (!evt_vld_in || (last_grant == GRANT_EVT));
        grant_evt  = !reset && stage_free && evt_vld_in &&
                     (!rpl_vld_in || (last_grant == GRANT_RPL));
        grant_any  = grant_rpl || grant_evt;
    end

    // Source handshakes follow the grant directly so acceptance is same-cycle.
    always_comb begin
        rpl_rdy_out = grant_rpl;
        evt_rdy_out = grant_evt;
    end

    // Packet assembly for whichever source is granted this cycle.
    always_comb begin
        if (grant_rpl) begin
            asm_pkt_p0 = build_packet(1'b1, 1'b1,
                                      {REPLY_KEY_BASE, rpl_addr_in},
                                      rpl_data_in);
        end else begin
            asm_pkt_p0 = build_packet(1'b0, evt_pld_in, evt_key_in,
                                      evt_data_in);
        end
    end

    // Sent-packet pulses, classified by the type bit of the packet leaving.
    always_comb begin
        ptx_cnt_out = 2'b00;
        if (!reset && pkt_vld_out && pkt_rdy_in) begin
            if (pkt_data_out[TYPE_BIT]) begin
                ptx_cnt_out = 2'b10;
            end else begin
                ptx_cnt_out = 2'b01;
            end
        end
    end

    // Arbitration history: remember the winner of every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_EVT;
        end else if (grant_rpl) begin
            last_grant <= GRANT_RPL;
        end else if (grant_evt) begin
            last_grant <= GRANT_EVT;
        end
    end

    // Output stage: load on grant (covers back-to-back handoff), drop valid
    // once the transceiver takes the packet and nothing new arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_vld_out  <= 1'b0;
            pkt_data_out <= '0;
        end else if (grant_any) begin
            pkt_vld_out  <= 1'b1;
            pkt_data_out <= asm_pkt_p0;
        end else if (pkt_rdy_in) begin
            pkt_vld_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_transmitter.sv
// tb_pkt_transmitter: scoreboard bench for pkt_transmitter. A per-cycle
// monitor models arbitration and the output register, pushes the expected
// packet on each grant and pops it when the packet leaves.
module tb_pkt_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rpl_addr_in;
    logic [31:0] rpl_data_in;
    logic        rpl_vld_in;
    logic        rpl_rdy_out;
    logic [31:0] evt_key_in;
    logic [31:0] evt_data_in;
    logic        evt_pld_in;
    logic        evt_vld_in;
    logic        evt_rdy_out;
    logic [71:0] pkt_data_out;
    logic        pkt_vld_out;
    logic        pkt_rdy_in;
    logic [1:0]  ptx_cnt_out;

    pkt_transmitter dut (
        .clk          (clk),
        .reset        (reset),
        .rpl_addr_in  (rpl_addr_in),
        .rpl_data_in  (rpl_data_in),
        .rpl_vld_in   (rpl_vld_in),
        .rpl_rdy_out  (rpl_rdy_out),
        .evt_key_in   (evt_key_in),
        .evt_data_in  (evt_data_in),
        .evt_pld_in   (evt_pld_in),
        .evt_vld_in   (evt_vld_in),
        .evt_rdy_out  (evt_rdy_out),
        .pkt_data_out (pkt_data_out),
        .pkt_vld_out  (pkt_vld_out),
        .pkt_rdy_in   (pkt_rdy_in),
        .ptx_cnt_out  (ptx_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } rpl_item_t;

    typedef struct {
        logic [31:0] key;
        logic [31:0] data;
        logic        pld;
    } evt_item_t;

    rpl_item_t   rpl_pend[$];
    evt_item_t   evt_pend[$];
    logic [71:0] exp_q[$];
    logic        out_types[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic rpl_acc  = 1'b0;
    logic evt_acc  = 1'b0;
    logic rand_rdy = 1'b0;

    // Model state: output-register valid, last winner (1 = reply), and
    // whether the register still holds its reset contents.
    logic m_vld  = 1'b0;
    logic m_last = 1'b0;
    logic m_zero = 1'b1;

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mk_pkt(input logic t, input logic p,
                                           input logic [31:0] key,
                                           input logic [31:0] pay);
        logic [71:0] v;
        v    = {pay, key, 2'b00, 1'b0, t, 2'b00, p, 1'b0};
        v[0] = ~(^v);
        return v;
    endfunction

    // Monitor/scoreboard, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        logic gr, ge, free;
        logic [71:0] front;
        logic [1:0]  exp_ptx;
        if (reset) begin
            chk("rdy_in_reset", {70'd0, rpl_rdy_out, evt_rdy_out}, 72'd0);
            chk("ptx_in_reset", {70'd0, ptx_cnt_out}, 72'd0);
            rpl_acc = 1'b0;
            evt_acc = 1'b0;
            m_vld   = 1'b0;
            m_last  = 1'b0;
            m_zero  = 1'b1;
            exp_q.delete();
        end else begin
            front = (exp_q.size() > 0) ? exp_q[0] : 72'd0;
            chk("pkt_vld", {71'd0, pkt_vld_out}, {71'd0, m_vld});
            if (m_vld) chk("pkt_data", pkt_data_out, front);
            else if (m_zero) chk("pkt_data_reset", pkt_data_out, 72'd0);
            free = !m_vld || pkt_rdy_in;
            gr   = free && rpl_vld_in && (!evt_vld_in || !m_last);
            ge   = free && evt_vld_in && (!rpl_vld_in || m_last);
            chk("rdy_pair", {70'd0, rpl_rdy_out, evt_rdy_out}, {70'd0, gr, ge});
            exp_ptx = 2'b00;
            if (m_vld && pkt_rdy_in) exp_ptx = front[4] ? 2'b10 : 2'b01;
            chk("ptx_cnt", {70'd0, ptx_cnt_out}, {70'd0, exp_ptx});
            if (m_vld && pkt_rdy_in) begin
                void'(exp_q.pop_front());
                chk("parity", {71'd0, ^pkt_data_out}, 72'd1);
                out_types.push_back(pkt_data_out[4]);
            end
            if (gr) begin
                exp_q.push_back(mk_pkt(1'b1, 1'b1, {24'hFFFE00, rpl_addr_in},
                                       rpl_data_in));
                m_last = 1'b1;
            end else if (ge) begin
                exp_q.push_back(mk_pkt(1'b0, evt_pld_in, evt_key_in,
                                       evt_pld_in ? evt_data_in : 32'h0));
                m_last = 1'b0;
            end
            if (gr || ge) begin
                m_vld  = 1'b1;
                m_zero = 1'b0;
            end else if (pkt_rdy_in) begin
                m_vld = 1'b0;
            end
            rpl_acc = rpl_vld_in && rpl_rdy_out;
            evt_acc = evt_vld_in && evt_rdy_out;
        end
    end

    // One clock of stimulus: present the next pending item once the current
    // one has been accepted, otherwise hold inputs stable.
    task automatic step();
        rpl_item_t r;
        evt_item_t e;
        @(posedge clk);
        #1;
        if (!rpl_vld_in || rpl_acc) begin
            if (rpl_pend.size() > 0) begin
                r           = rpl_pend.pop_front();
                rpl_addr_in = r.addr;
                rpl_data_in = r.data;
                rpl_vld_in  = 1'b1;
            end else begin
                rpl_vld_in = 1'b0;
            end
        end
        if (!evt_vld_in || evt_acc) begin
            if (evt_pend.size() > 0) begin
                e           = evt_pend.pop_front();
                evt_key_in  = e.key;
                evt_data_in = e.data;
                evt_pld_in  = e.pld;
                evt_vld_in  = 1'b1;
            end else begin
                evt_vld_in = 1'b0;
            end
        end
        if (rand_rdy) pkt_rdy_in = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int maxc);
        int   n;
        logic busy;
        n = 0;
        do begin
            step();
            n++;
            busy = (rpl_pend.size() > 0) || (evt_pend.size() > 0) ||
                   rpl_vld_in || evt_vld_in || pkt_vld_out;
        end while (busy && n < maxc);
        chk("drain_done", {71'd0, busy}, 72'd0);
    endtask

    task automatic push_rpl(input logic [7:0] a, input logic [31:0] d);
        rpl_item_t r;
        r.addr = a;
        r.data = d;
        rpl_pend.push_back(r);
    endtask

    task automatic push_evt(input logic [31:0] k, input logic [31:0] d,
                            input logic p);
        evt_item_t e;
        e.key  = k;
        e.data = d;
        e.pld  = p;
        evt_pend.push_back(e);
    endtask

    initial begin
        logic [3:0] order;
        reset       = 1'b1;
        rpl_addr_in = '0;
        rpl_data_in = '0;
        rpl_vld_in  = 1'b0;
        evt_key_in  = '0;
        evt_data_in = '0;
        evt_pld_in  = 1'b0;
        evt_vld_in  = 1'b0;
        pkt_rdy_in  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single reply.
        pkt_rdy_in = 1'b1;
        push_rpl(8'h05, 32'hDEADBEEF);
        step();
        step();
        @(negedge clk);
        chk("rpl_key",  {40'd0, pkt_data_out[39:8]},  {40'd0, 32'hFFFE0005});
        chk("rpl_pay",  {40'd0, pkt_data_out[71:40]}, {40'd0, 32'hDEADBEEF});
        chk("rpl_hdr",  {66'd0, pkt_data_out[7:1]}, {66'd0, 7'b0001001});
        chk("rpl_ptx",  {70'd0, ptx_cnt_out}, {70'd0, 2'b10});
        drain(50);

        // Event without payload; stale data must not leak into the payload.
        push_evt(32'h12345678, 32'hCAFEF00D, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("evt_key", {40'd0, pkt_data_out[39:8]},  {40'd0, 32'h12345678});
        chk("evt_pay", {40'd0, pkt_data_out[71:40]}, 72'd0);
        chk("evt_hdr", {66'd0, pkt_data_out[7:1]}, 72'd0);
        chk("evt_ptx", {70'd0, ptx_cnt_out}, {70'd0, 2'b01});
        drain(50);

        // Both sources valid together: strict alternation starting with reply.
        out_types.delete();
        push_rpl(8'h11, 32'h0000_1111);
        push_rpl(8'h22, 32'h0000_2222);
        push_evt(32'hA0A0_0001, 32'h1, 1'b1);
        push_evt(32'hA0A0_0002, 32'h2, 1'b1);
        drain(50);
        order = 4'b0;
        for (int i = 0; i < 4 && i < out_types.size(); i++)
            order[3-i] = out_types[i];
        chk("alt_count", 72'(out_types.size()), 72'd4);
        chk("alt_order", {68'd0, order}, {68'd0, 4'b1010});

        // Backpressure for 5 cycles, then release with back-to-back handoff.
        pkt_rdy_in = 1'b0;
        push_rpl(8'h33, 32'h3333_3333);
        push_rpl(8'h44, 32'h4444_4444);
        push_evt(32'hB0B0_0001, 32'h5555_5555, 1'b1);
        push_evt(32'hB0B0_0002, 32'h6666_6666, 1'b0);
        repeat (7) step();
        pkt_rdy_in = 1'b1;
        drain(50);

        // Reset while a packet is stalled.
        pkt_rdy_in = 1'b0;
        push_rpl(8'h55, 32'h7777_7777);
        push_rpl(8'h66, 32'h8888_8888);
        push_evt(32'hC0C0_0001, 32'h9999_9999, 1'b1);
        push_evt(32'hC0C0_0002, 32'hAAAA_AAAA, 1'b1);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_vld",   {71'd0, pkt_vld_out}, 72'd0);
        chk("rst_data",  pkt_data_out, 72'd0);
        chk("rst_first", {70'd0, rpl_rdy_out, evt_rdy_out}, {70'd0, 2'b10});
        pkt_rdy_in = 1'b1;
        drain(50);

        // Random sweep with random transceiver backpressure.
        for (int i = 0; i < 500; i++) begin
            push_rpl(8'($urandom), $urandom);
            push_evt($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b1;
        drain(20000);
        rand_rdy   = 1'b0;
        pkt_rdy_in = 1'b1;
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
